// File: rtl/tone_bank.sv
// Polyphonic square-wave tone bank: per-channel programmable half-period,
// key-gated with phase restart, summed into a mix level rendered as PWM.
module tone_bank #(
  parameter int NUM_CH = 36,
  parameter int CNT_W  = 21,
  parameter int AW     = 6,
  parameter int LW     = $clog2(NUM_CH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] key,
  input  logic              cfg_we,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [CNT_W-1:0]  cfg_data,
  output logic [NUM_CH-1:0] tone,
  output logic [LW-1:0]     mix_level,
  output logic              pwm_out
);

  localparam logic [LW-1:0] PWM_LAST = LW'(NUM_CH - 1);

  logic [NUM_CH-1:0] key_p0;
  logic [NUM_CH-1:0] key_s;
  logic [CNT_W-1:0]  half [NUM_CH];
  logic [CNT_W-1:0]  cnt  [NUM_CH];
  logic [LW-1:0]     pwm_cnt;
  logic [LW-1:0]     pwm_lvl;

  function automatic logic [LW-1:0] popcount(input logic [NUM_CH-1:0] v);
    logic [LW-1:0] sum;
    sum = '0;
    for (int i = 0; i < NUM_CH; i++) sum = sum + LW'(v[i]);
    return sum;
  endfunction

  // Stage 0/1: two-flop synchroniser on the asynchronous key levels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_p0 <= '0;
      key_s  <= '0;
    end else begin
      key_p0 <= key;
      key_s  <= key_p0;
    end
  end

  // Half-period registers; indices beyond NUM_CH match no channel and are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) half[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++)
        if (cfg_we && (cfg_addr == AW'(i))) half[i] <= cfg_data;
    end
  end

  // Stage 2: per-channel counter; >= compare lets a shrunk half toggle at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
      tone <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!key_s[i] || (half[i] == '0)) begin
          cnt[i]  <= '0;
          tone[i] <= 1'b0;
        end else if (cnt[i] >= (half[i] - CNT_W'(1))) begin
          cnt[i]  <= '0;
          tone[i] <= ~tone[i];
        end else begin
          cnt[i]  <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Stage 3: mix level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mix_level <= '0;
    else        mix_level <= popcount(tone);
  end

  // Stage 4: PWM frame of NUM_CH cycles; level is held for a whole frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
      pwm_lvl <= '0;
      pwm_out <= 1'b0;
    end else begin
      if (pwm_cnt == PWM_LAST) begin
        pwm_cnt <= '0;
        pwm_lvl <= mix_level;
      end else begin
        pwm_cnt <= pwm_cnt + LW'(1);
      end
      pwm_out <= (pwm_cnt < pwm_lvl);
    end
  end

endmodule

// File: tb/tb_tone_bank.sv
// Directed bench for tone_bank with NUM_CH=4, CNT_W=8; AW=3 so that
// out-of-range config addresses exist.
module tb_tone_bank;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;
  localparam int AW     = 3;
  localparam int LW     = $clog2(NUM_CH + 1);

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NUM_CH-1:0] key;
  logic              cfg_we;
  logic [AW-1:0]     cfg_addr;
  logic [CNT_W-1:0]  cfg_data;
  logic [NUM_CH-1:0] tone;
  logic [LW-1:0]     mix_level;
  logic              pwm_out;

  int errors = 0;
  int checks = 0;
  int cyc;

  tone_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .key(key), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .tone(tone), .mix_level(mix_level), .pwm_out(pwm_out)
  );

  always #5 clk = ~clk;

  // edges since reset release; pwm_cnt after edge c is c mod NUM_CH
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [CNT_W-1:0] d);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    tick();
    cfg_we   = 1'b0;
  endtask

  initial begin
    logic e, p, e1, e2, p1, p2;
    rst_n = 1'b0; key = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;

    // reset state
    repeat (2) tick();
    check("rst_tone", tone, 0);
    check("rst_mix", mix_level, 0);
    check("rst_pwm", pwm_out, 0);
    rst_n = 1'b1;
    repeat (3) tick();
    check("idle_tone", tone, 0);

    // basic tone, H=5 on ch0
    wr(0, 5);
    key[0] = 1'b1;
    tick();
    p = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      e = ((k >= 6) && (k < 11)) || (k >= 16);
      check("t2_tone0", tone[0], e);
      check("t2_mix", mix_level, p);
      p = e;
    end

    // phase reset: drop key mid half-period for 3 cycles
    repeat (2) tick();
    key[0] = 1'b0;
    repeat (3) tick();
    check("t4_drop", tone[0], 0);
    key[0] = 1'b1;
    tick();
    for (int k = 1; k <= 6; k++) begin
      tick();
      check("t4_restart", tone[0], (k >= 6));
    end

    // short period and ignored addresses
    key = '0;
    repeat (4) tick();
    wr(1, 1);
    wr(2, 3);
    wr(4, 9);
    wr(7, 9);
    key = 4'b1110;
    tick();
    p1 = 1'b0; p2 = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      e1 = (k >= 2) && ((k % 2) == 0);
      e2 = (k >= 4) && ((((k - 4) / 3) % 2) == 0);
      check("t3_tone1", tone[1], e1);
      check("t3_tone2", tone[2], e2);
      check("t3_tone3", tone[3], 0);
      check("t3_mix", mix_level, 32'(p1) + 32'(p2));
      p1 = e1; p2 = e2;
    end

    // shrink H from 200 to 10 while cnt is at 150
    key = '0;
    repeat (4) tick();
    wr(0, 200);
    key[0] = 1'b1;
    tick();
    repeat (150) tick();
    check("t5_pre", tone[0], 0);
    wr(0, 10);
    check("t5_wr", tone[0], 0);
    tick();
    check("t5_toggle", tone[0], 1);
    repeat (9) tick();
    check("t5_hold1", tone[0], 1);
    tick();
    check("t5_fall", tone[0], 0);
    repeat (9) tick();
    check("t5_hold0", tone[0], 0);
    tick();
    check("t5_rise", tone[0], 1);

    // PWM with 3 of 4 channels high
    key = '0;
    repeat (4) tick();
    wr(0, 100);
    wr(1, 100);
    wr(2, 100);
    key = 4'b0111;
    tick();
    repeat (100) tick();
    check("t6_before", tone, 0);
    tick();
    check("t6_tone3", tone, 7);
    repeat (10) tick();
    check("t6_mix3", mix_level, 3);
    for (int k = 0; k < 8; k++) begin
      tick();
      check("t6_pwm3", pwm_out, ((cyc % NUM_CH) != 0));
    end

    // PWM with all channels high
    key = '0;
    repeat (4) tick();
    wr(3, 100);
    key = 4'hF;
    tick();
    repeat (110) tick();
    check("t6_tone4", tone, 15);
    check("t6_mix4", mix_level, 4);
    for (int k = 0; k < 8; k++) begin
      tick();
      check("t6_pwm4", pwm_out, 1);
    end

    // asynchronous reset mid-note, then silence until rewritten
    #3;
    rst_n = 1'b0;
    #1;
    check("t1_async_tone", tone, 0);
    check("t1_async_mix", mix_level, 0);
    check("t1_async_pwm", pwm_out, 0);
    tick();
    rst_n = 1'b1;
    key = 4'hF;
    for (int k = 0; k < 4; k++) begin
      repeat (5) tick();
      check("t1_silent", tone, 0);
    end
    check("t1_silent_mix", mix_level, 0);
    check("t1_silent_pwm", pwm_out, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
